dma_priority_arb: RTL

Parametrised N-channel DMA request arbiter, the successor to the 4-channel priority logic. It qualifies DREQ lines (polarity, mask, software request) and picks one channel with fixed or rotating priority. It runs the HRQ/HLDA hold handshake with the CPU and drives one-hot DACK until the timing/control block signals end of service. It sits between the DMA register file (config inputs) and the transfer timing FSM (xfer_done).

---
 rtl/dma_priority_arb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dma_priority_arb.sv
// N-channel DMA request arbiter: qualifies DREQ/sw_req, runs the HRQ/HLDA handshake and
// holds a one-hot DACK grant (fixed or rotating priority) until xfer_done.
module dma_priority_arb #(
    parameter int NUM_CH = 4,
    parameter int CHW    = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] mask,
    input  logic [NUM_CH-1:0] sw_req,
    input  logic              rotate_en,
    input  logic              dreq_low,
    input  logic              dack_low,
    input  logic              HLDA,
    input  logic              xfer_done,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grant_valid,
    output logic [CHW-1:0]    grant_ch,
    output logic [NUM_CH-1:0] sw_req_clr
);

    typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;

    state_t            r_state;
    logic [NUM_CH-1:0] r_req_q;
    logic [NUM_CH-1:0] r_ack_q;
    logic [NUM_CH-1:0] r_sw_req_clr;
    logic [CHW-1:0]    r_rot_ptr;
    logic [CHW-1:0]    r_grant_ch;
    logic              r_hrq;
    logic              r_grant_valid;
    logic              r_sw_grant;

    logic [NUM_CH-1:0] w_qual;
    logic              w_any;
    logic [CHW-1:0]    w_base;
    logic [CHW-1:0]    w_pick;
    logic [CHW-1:0]    w_next_ptr;
    logic [CHW:0]      w_idx;

    assign w_qual = ((DREQ ^ {NUM_CH{dreq_low}}) & ~mask) | sw_req;
    assign w_any  = |r_req_q;
    assign w_base = rotate_en ? r_rot_ptr : '0;

    // Scan offsets from farthest to nearest so the nearest requester to w_base wins.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = {1'b0, w_base} + (CHW + 1)'(i);
            if (w_idx >= (CHW + 1)'(NUM_CH)) begin
                w_idx = w_idx - (CHW + 1)'(NUM_CH);
            end
            if (r_req_q[w_idx[CHW-1:0]]) begin
                w_pick = w_idx[CHW-1:0];
            end
        end
    end

    // Explicit wrap keeps the pointer in range for non-power-of-2 channel counts.
    assign w_next_ptr = (r_grant_ch == CHW'(NUM_CH - 1)) ? '0 : r_grant_ch + CHW'(1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_req_q       <= '0;
            r_ack_q       <= '0;
            r_sw_req_clr  <= '0;
            r_rot_ptr     <= '0;
            r_grant_ch    <= '0;
            r_hrq         <= 1'b0;
            r_grant_valid <= 1'b0;
            r_sw_grant    <= 1'b0;
        end else begin
            r_req_q      <= w_qual;
            r_sw_req_clr <= '0;
            if (!rotate_en) begin
                r_rot_ptr <= '0;
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= REQ;
                        r_hrq   <= 1'b1;
                    end
                end
                REQ: begin
                    if (!w_any) begin
                        r_state <= IDLE;
                        r_hrq   <= 1'b0;
                    end else if (HLDA) begin
                        r_state       <= GRANT;
                        r_grant_ch    <= w_pick;
                        r_grant_valid <= 1'b1;
                        r_ack_q       <= {{(NUM_CH - 1){1'b0}}, 1'b1} << w_pick;
                        r_sw_grant    <= sw_req[w_pick];
                    end
                end
                GRANT: begin
                    if (xfer_done) begin
                        r_state       <= IDLE;
                        r_hrq         <= 1'b0;
                        r_grant_valid <= 1'b0;
                        r_ack_q       <= '0;
                        if (rotate_en) begin
                            r_rot_ptr <= w_next_ptr;
                        end
                        if (r_sw_grant) begin
                            r_sw_req_clr[r_grant_ch] <= 1'b1;
                        end
                    end else if (!HLDA) begin
                        r_state       <= IDLE;
                        r_hrq         <= 1'b0;
                        r_grant_valid <= 1'b0;
                        r_ack_q       <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign HRQ         = r_hrq;
    assign DACK        = r_ack_q ^ {NUM_CH{dack_low}};
    assign grant_valid = r_grant_valid;
    assign grant_ch    = r_grant_ch;
    assign sw_req_clr  = r_sw_req_clr;

endmodule
